memory_stage: RTL

Memory stage of the five-stage pipeline, directly downstream of the execute/memory latch. It issues the data-cache request for loads and stores and holds that request until `dhit`, stalling upstream meanwhile. It resolves branches and jumps into a PC redirect plus flush, and registers the writeback bundle (MEM/WB latch) for the register file. It also latches halt and tracks memory-stall cycles for performance debug.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/memory_stage_if.sv | 51 +++++
 rtl/memory_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU word/register types and memory-stage FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } memstage_state_t;

    localparam regbits_t RA_REG = 5'd31;

endpackage

`default_nettype wire

// File: rtl/memory_stage_if.sv
// ============================================================================
// Module : memory_stage_if
// Brief  : Execute-side inputs, data-cache handshake and writeback bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface memory_stage_if;
    import cpu_types_pkg::*;

    word_t    ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2;
    logic     ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL;
    logic     ex_MemtoReg, ex_dREN, ex_dWEN, ex_regWEN, ex_halt;
    regbits_t ex_wsel;

    logic     dhit;
    word_t    dmemload;
    logic     dmemREN, dmemWEN;
    word_t    dmemaddr, dmemstore;

    logic     mem_busy;
    logic     redirect;
    word_t    redirect_addr;

    logic     wb_regWEN, wb_halt;
    regbits_t wb_wsel;
    word_t    wb_wdat;

    modport ms (
        input  ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2,
        input  ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL,
        input  ex_MemtoReg, ex_dREN, ex_dWEN, ex_regWEN, ex_halt, ex_wsel,
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output mem_busy, redirect, redirect_addr,
        output wb_regWEN, wb_halt, wb_wsel, wb_wdat
    );

    modport tb (
        output ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2,
        output ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL,
        output ex_MemtoReg, ex_dREN, ex_dWEN, ex_regWEN, ex_halt, ex_wsel,
        output dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  mem_busy, redirect, redirect_addr,
        input  wb_regWEN, wb_halt, wb_wsel, wb_wdat
    );

endinterface

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// Module : memory_stage
// Brief  : Pipeline MEM stage: cache request/stall, branch redirect, MEM/WB latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_stage
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  wire logic                   CLK,
    input  wire logic                   nRST,
    memory_stage_if.ms                  bus,
    output logic [STALL_CNT_W-1:0]      stall_cnt
);

    memstage_state_t          r_state;
    memstage_state_t          w_next_state;
    logic                     w_halted;
    logic                     w_req;
    logic                     w_busy;
    logic                     w_taken;

    logic                     r_wb_regwen;
    logic                     r_wb_halt;
    regbits_t                 r_wb_wsel;
    word_t                    r_wb_wdat;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;

    // Gating with nRST drops an in-flight request the moment reset asserts.
    assign w_halted = (r_state == HALTED);
    assign w_req    = (bus.ex_dREN | bus.ex_dWEN) & ~w_halted & nRST;
    assign w_busy   = w_req & ~bus.dhit;
    assign w_taken  = bus.ex_Branch & (bus.ex_zero ^ bus.ex_bne);

    assign bus.dmemWEN   = w_req & bus.ex_dWEN;
    assign bus.dmemREN   = w_req & bus.ex_dREN & ~bus.ex_dWEN;
    assign bus.dmemaddr  = bus.ex_portout;
    assign bus.dmemstore = bus.ex_rdat2;
    assign bus.mem_busy  = w_busy;

    // A halting instruction suppresses any redirect it also carries.
    assign bus.redirect      = (w_taken | bus.ex_Jump) & ~w_busy & ~w_halted & ~bus.ex_halt;
    assign bus.redirect_addr = w_taken ? bus.ex_baddr : bus.ex_jaddr;

    assign bus.wb_regWEN = r_wb_regwen;
    assign bus.wb_halt   = r_wb_halt;
    assign bus.wb_wsel   = r_wb_wsel;
    assign bus.wb_wdat   = r_wb_wdat;
    assign stall_cnt     = r_stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.ex_halt & ~w_busy) begin
                    w_next_state = HALTED;
                end else if (w_busy) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.ex_halt & ~w_busy) begin
                    w_next_state = HALTED;
                end else if (bus.dhit) begin
                    w_next_state = IDLE;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wb_regwen <= 1'b0;
            r_wb_halt   <= 1'b0;
            r_wb_wsel   <= '0;
            r_wb_wdat   <= '0;
        end else if (w_halted) begin
            r_wb_regwen <= 1'b0;
        end else if (w_busy) begin
            r_wb_regwen <= 1'b0;
            r_wb_halt   <= 1'b0;
        end else begin
            r_wb_regwen <= bus.ex_regWEN;
            r_wb_halt   <= bus.ex_halt;
            r_wb_wsel   <= bus.ex_JAL ? RA_REG : bus.ex_wsel;
            r_wb_wdat   <= bus.ex_JAL      ? bus.ex_pc_plus_4 :
                           bus.ex_MemtoReg ? bus.dmemload     : bus.ex_portout;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (w_busy && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire
